// File: rtl/flit_receiver_pkg.sv
// Shared definitions for the switch datapath: FSM state encoding and flit width formula.
// Imported by both the receiver and the transceiver so the encodings stay in sync.
package flit_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // Flit = valid/flag bit + payload + destination address.
    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

endpackage

// File: rtl/flit_receiver_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping modulo N) wins.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N = 5,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    always_comb begin
        // Rotate so that bit 0 of rot is the port the pointer names.
        rot = N'({req, req} >> ptr);
        any = 1'b0;
        off = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[W'(k)]) begin
                any = 1'b1;
                off = W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        grant_idx = sum[W-1:0];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign grant[gi] = any && (grant_idx == W'(gi));
    end

endmodule

// File: rtl/flit_receiver.sv
// Switch input side: round-robin accepts flits from neighbour and local links over a
// four-phase wr_ready/r_ready handshake and writes each one into the input queue.
module flit_receiver
    import flit_receiver_pkg::*;
#(
    parameter int ADDR      = 0,
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    parameter int NODES_NUM = 9,
    parameter int CNT_SIZE  = 16,
    localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                              clk,
    input  logic                              a_rst,
    input  logic [PORTS_NUM:0]                wr_ready_in,
    input  logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_i,
    input  logic                              mem_full,
    output logic [PORTS_NUM:0]                r_ready_out,
    output logic                              mem_wr,
    output logic [BUS_SIZE-1:0]               data_o,
    output logic [CNT_SIZE-1:0]               flits_cnt
);

    localparam int N     = PORTS_NUM + 1;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // ADDR and NODES_NUM carry no logic here; they are kept for parameter-list parity.
    if (ADDR < 0 || NODES_NUM < 1) begin : g_bad_params
    end

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    ptr_reg, ptr_next;
    logic [PTR_W-1:0]    port_reg, port_next;
    logic [BUS_SIZE-1:0] flit_reg, flit_next;
    logic [N-1:0]        rdy_reg, rdy_next;
    logic                wr_reg, wr_next;
    logic [CNT_SIZE-1:0] cnt_reg, cnt_next;

    logic [N-1:0]        req;
    logic [N-1:0]        grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                any_req;
    logic [BUS_SIZE-1:0] masked [N];
    logic [BUS_SIZE-1:0] sel_flit;

    // Only a solid 1 is a request, so floating or unknown links stay idle.
    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign req[gi]    = (wr_ready_in[gi] === 1'b1);
        assign masked[gi] = grant[gi] ? data_i[gi*BUS_SIZE +: BUS_SIZE] : '0;
    end

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < N; i++) begin
            sel_flit = sel_flit | masked[i];
        end
    end

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_reg),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any_req)
    );

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            port_reg  <= '0;
            flit_reg  <= '0;
            rdy_reg   <= '0;
            wr_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            port_reg  <= port_next;
            flit_reg  <= flit_next;
            rdy_reg   <= rdy_next;
            wr_reg    <= wr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        port_next  = port_reg;
        flit_next  = flit_reg;
        rdy_next   = rdy_reg;
        wr_next    = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    port_next  = grant_idx;
                    flit_next  = sel_flit;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!mem_full) begin
                    wr_next            = 1'b1;
                    rdy_next           = '0;
                    rdy_next[port_reg] = 1'b1;
                    cnt_next           = cnt_reg + 1'b1;
                    state_next         = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req[port_reg]) begin
                    rdy_next   = '0;
                    ptr_next   = (port_reg == PTR_W'(PORTS_NUM)) ? '0 : port_reg + 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                rdy_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign r_ready_out = rdy_reg;
    assign mem_wr      = wr_reg;
    assign data_o      = flit_reg;
    assign flits_cnt   = cnt_reg;

endmodule

// File: tb/tb_flit_receiver.sv
// Bench for flit_receiver: table of single-flit transactions plus hand-written sequences,
// with a scoreboard of driven flits checked whenever the queue write strobe fires.
module tb_flit_receiver;

    localparam int NP  = 5;
    localparam int BUS = 37;
    localparam int CW  = 4;

    logic                clk = 1'b0;
    logic                a_rst = 1'b0;
    logic [NP-1:0]       wr_ready_in = '0;
    logic [BUS*NP-1:0]   data_i = '0;
    logic                mem_full = 1'b0;
    logic [NP-1:0]       r_ready_out;
    logic                mem_wr;
    logic [BUS-1:0]      data_o;
    logic [CW-1:0]       flits_cnt;

    flit_receiver #(
        .ADDR(0), .DATA_SIZE(32), .ADDR_SIZE(4), .PORTS_NUM(4), .NODES_NUM(9), .CNT_SIZE(CW)
    ) dut (
        .clk(clk), .a_rst(a_rst), .wr_ready_in(wr_ready_in), .data_i(data_i),
        .mem_full(mem_full), .r_ready_out(r_ready_out), .mem_wr(mem_wr),
        .data_o(data_o), .flits_cnt(flits_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             port;
        logic [BUS-1:0] data;
    } sb_t;

    typedef struct {
        int             port;
        logic [BUS-1:0] flit;
        int             stall;
        int             lat;
    } vec_t;

    sb_t            sb[$];
    int             got_ports[$];
    vec_t           vec[5];
    int             pend[NP];
    logic [BUS-1:0] next_flit[NP];
    logic [NP-1:0]  hold_req = '0;
    logic           xz_mode = 1'b0;
    logic           prev_wr = 1'b0;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             exp_cnt = 0;
    int             lat;
    int             base;
    int             order[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec[0] = '{2, BUS'(40'h5_DEADBEEF_3), 0, 2};
        vec[1] = '{4, BUS'(40'h0_12345678_9), 10, 11};
        vec[2] = '{0, BUS'(40'h1_CAFEF00D_0), 0, 2};
        vec[3] = '{3, BUS'(40'h0_0BADC0DE_7), 1, 2};
        vec[4] = '{1, BUS'(40'h1_FFFFFFFF_F), 3, 4};
        order  = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        for (int p = 0; p < NP; p++) begin
            pend[p]      = 0;
            next_flit[p] = '0;
        end

        fork
            // Upstream senders: raise with data, drop after r_ready, re-raise only once r_ready is low.
            forever begin
                @(negedge clk);
                if (!a_rst) begin
                    wr_ready_in = '0;
                end else begin
                    for (int p = 0; p < NP; p++) begin
                        if (wr_ready_in[p] === 1'b1) begin
                            if (r_ready_out[p] && !hold_req[p]) wr_ready_in[p] = 1'b0;
                        end else if (!r_ready_out[p] && pend[p] > 0) begin
                            data_i[p*BUS +: BUS] = next_flit[p];
                            sb.push_back('{p, next_flit[p]});
                            next_flit[p] = next_flit[p] + 1'b1;
                            pend[p]      = pend[p] - 1;
                            wr_ready_in[p] = 1'b1;
                        end
                    end
                    if (xz_mode && wr_ready_in[0] === 1'b1) begin
                        wr_ready_in[1] = 1'bz;
                        wr_ready_in[3] = 1'bx;
                    end else if (xz_mode) begin
                        wr_ready_in[1] = 1'b0;
                        wr_ready_in[3] = 1'b0;
                    end
                end
            end
            // Monitor: every queue write must match a driven flit of the acknowledged port.
            forever begin
                @(negedge clk);
                if (a_rst) begin
                    chk("rdy_onehot", 64'($countones(r_ready_out) <= 1), 64'd1);
                    if (mem_wr) begin
                        int port;
                        int idx;
                        port = -1;
                        idx  = -1;
                        for (int p = NP - 1; p >= 0; p--) if (r_ready_out[p]) port = p;
                        chk("wr_single_cycle", 64'(prev_wr), 64'd0);
                        chk("wr_with_ack", 64'($countones(r_ready_out)), 64'd1);
                        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].port == port) idx = i;
                        if (idx < 0) begin
                            chk("sb_entry_exists", 64'd0, 64'd1);
                        end else begin
                            chk("data_o", 64'(data_o), 64'(sb[idx].data));
                            sb.delete(idx);
                        end
                        got_ports.push_back(port);
                        $display("t=%0t write port=%0d data=%h cnt=%0d", $time, port, data_o, flits_cnt);
                    end
                end
                prev_wr = mem_wr;
            end
        join_none

        // Reset state, held across clock edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 64'(r_ready_out), 64'd0);
        chk("rst_wr", 64'(mem_wr), 64'd0);
        chk("rst_cnt", 64'(flits_cnt), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        @(posedge clk); #2;
        a_rst = 1'b1;

        // Single-flit transactions with optional queue-full stalls.
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #2;
            mem_full = (vec[v].stall > 0);
            next_flit[vec[v].port] = vec[v].flit;
            pend[vec[v].port] = 1;
            @(negedge clk);
            lat = -1;
            for (int n = 1; n <= 40 && lat < 0; n++) begin
                @(negedge clk);
                if (mem_wr) lat = n;
                else chk($sformatf("stall_rdy_v%0d", v), 64'(r_ready_out), 64'd0);
                if (n == vec[v].stall) mem_full = 1'b0;
            end
            mem_full = 1'b0;
            chk($sformatf("latency_v%0d", v), 64'(lat), 64'(vec[v].lat));
            chk($sformatf("ack_v%0d", v), 64'(r_ready_out), 64'(1) << vec[v].port);
            exp_cnt = (exp_cnt + 1) % 16;
            @(negedge clk);
            chk($sformatf("ack_drop_v%0d", v), 64'(r_ready_out), 64'd0);
            chk($sformatf("wr_drop_v%0d", v), 64'(mem_wr), 64'd0);
            chk($sformatf("cnt_v%0d", v), 64'(flits_cnt), 64'(exp_cnt));
        end

        // Reset asserted mid-ACK clears outputs without a clock edge.
        @(posedge clk); #2;
        hold_req[2] = 1'b1;
        pend[2] = 1;
        lat = -1;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            @(negedge clk);
            if (mem_wr) lat = n;
        end
        chk("rst_pre_wr_seen", 64'(lat >= 0), 64'd1);
        @(negedge clk);
        chk("rst_pre_ack_held", 64'(r_ready_out), 64'd4);
        #1;
        a_rst = 1'b0;
        hold_req = '0;
        for (int p = 0; p < NP; p++) pend[p] = 0;
        #1;
        chk("async_rst_rdy", 64'(r_ready_out), 64'd0);
        chk("async_rst_wr", 64'(mem_wr), 64'd0);
        chk("async_rst_cnt", 64'(flits_cnt), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        exp_cnt = 0;
        repeat (3) @(posedge clk);
        #2;
        a_rst = 1'b1;

        // All ports request continuously from reset: strict round-robin order.
        @(posedge clk); #2;
        base = got_ports.size();
        for (int p = 0; p < NP; p++) pend[p] = 2;
        for (int n = 0; n < 300 && got_ports.size() < base + 10; n++) @(negedge clk);
        chk("rr_count", 64'(got_ports.size() - base), 64'd10);
        if (got_ports.size() >= base + 10) begin
            for (int i = 0; i < 10; i++) chk($sformatf("rr_order_%0d", i), 64'(got_ports[base+i]), 64'(order[i]));
        end
        repeat (4) @(negedge clk);
        exp_cnt = (exp_cnt + 10) % 16;
        chk("rr_cnt", 64'(flits_cnt), 64'(exp_cnt));
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Z and X on ports 1 and 3 are not requests.
        a_rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        a_rst = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #2;
        xz_mode = 1'b1;
        base = got_ports.size();
        pend[0] = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("xz_rdy13", 64'({r_ready_out[3], r_ready_out[1]}), 64'd0);
        end
        xz_mode = 1'b0;
        chk("xz_count", 64'(got_ports.size() - base), 64'd1);
        if (got_ports.size() > base) chk("xz_port", 64'(got_ports[base]), 64'd0);

        // Counter wraps modulo 2^CNT_SIZE.
        a_rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        a_rst = 1'b1;
        @(posedge clk); #2;
        base = got_ports.size();
        pend[0] = 17;
        for (int n = 0; n < 400 && got_ports.size() < base + 17; n++) @(negedge clk);
        chk("wrap_count", 64'(got_ports.size() - base), 64'd17);
        repeat (4) @(negedge clk);
        chk("wrap_cnt", 64'(flits_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flit_receiver.md
# flit_receiver

Input-side counterpart of the switch transceiver. It accepts flits from the PORTS_NUM neighbour links plus the local port (index PORTS_NUM) using the four-phase wr_ready/r_ready handshake, and arbitrates round-robin among them. Each granted flit is written into the switch input queue, where the transceiver later picks it up.

## Interface
- ADDR, 0, address of this switch; reported in debug only, no filtering
- DATA_SIZE, 32, payload width
- ADDR_SIZE, 4, destination address width (flit bits [ADDR_SIZE-1:0])
- PORTS_NUM, 4, number of neighbour ports; local port is index PORTS_NUM
- NODES_NUM, 9, nodes in the network; kept for parameter-list parity
- BUS_SIZE (localparam), DATA_SIZE+ADDR_SIZE+1, flit width
- CNT_SIZE, 16, width of received-flit counter

Ports:
- clk  in  1  clock, all logic on rising edge
- a_rst  in  1  reset, asynchronous, active-low
- wr_ready_in  in  PORTS_NUM+1  per-port "flit valid" from upstream senders
- data_i  in  BUS_SIZE*(PORTS_NUM+1)  per-port flit bus; port p at [p*BUS_SIZE +: BUS_SIZE]
- mem_full  in  1  input queue cannot accept a write
- r_ready_out  out  PORTS_NUM+1  per-port "flit taken" acknowledge
- mem_wr  out  1  one-cycle queue write strobe
- data_o  out  BUS_SIZE  flit written to the queue
- flits_cnt  out  CNT_SIZE  number of flits accepted since reset

## Operation
- Request on port p: wr_ready_in[p] === 1'b1. X or Z counts as no request, so unconnected ports are idle.
- FSM states:
  - IDLE: if any request, the arbiter grants port g. Latch g into port_r and data_i slice g into flit_r, then go to WRITE. With no request, stay in IDLE.
  - WRITE: if !mem_full, assert mem_wr and r_ready_out[port_r], increment flits_cnt, and go to ACK. Otherwise stay in WRITE; mem_wr=0 and nothing is acknowledged.
  - ACK: hold r_ready_out[port_r]=1 until wr_ready_in[port_r] !== 1. Then clear r_ready_out[port_r], set the RR pointer to port_r+1 (wrapping PORTS_NUM -> 0), and go to IDLE.
  - Illegal encoding: go to IDLE.
- Round-robin arbitration:
  - The search starts at the pointer and wraps modulo PORTS_NUM+1.
  - The first requesting port wins.
  - The pointer updates only on ACK exit.
- data_o = flit_r; it is only valid while mem_wr=1.
- flits_cnt wraps modulo 2^CNT_SIZE.
- At most one bit of r_ready_out is high at any time.

## Timing
- Reset (a_rst=0, immediate):
  - state=IDLE, pointer=0
  - r_ready_out=0, mem_wr=0, data_o=0, flits_cnt=0
- Latency from wr_ready_in[p] rising with the queue not full:
  - grant/latch at edge 1
  - mem_wr and r_ready_out[p] high after edge 2
  - r_ready_out[p] low one edge after wr_ready_in[p] is seen low
- mem_wr is high for exactly one cycle per flit.
- data_i is sampled only in IDLE at the grant edge. The sender must hold data stable until it sees r_ready.
- The sender must not re-raise wr_ready_in[p] while r_ready_out[p]=1. The receiver must not re-grant p until r_ready_out[p] has been low for at least one cycle, which the ACK -> IDLE path guarantees.
- mem_full in WRITE stalls indefinitely. The sender keeps wr_ready high and no data is lost.
- A request on another port during WRITE/ACK waits; it is arbitrated in the next IDLE.
- Reset in WRITE or ACK drops r_ready_out immediately. An un-acked flit is not written. A flit already written stays counted until the counter clears.

## Structure
- Shared package holds the FSM state constants (IDLE, WRITE, ACK) and the BUS_SIZE formula; the transceiver uses the same ones.
- Sub-module rr_arbiter:
  - parameter N = PORTS_NUM+1
  - inputs: req[N], ptr
  - outputs: one-hot grant, grant index, any
  - purely combinational; the pointer register stays in flit_receiver.

## Test plan
- Reset: drive a_rst=0 mid-ACK -> r_ready_out=0, mem_wr=0, flits_cnt=0 with no clock edge.
- Single flit on port 2, data 0x5_DEADBEEF_3 -> mem_wr for 1 cycle with data_o equal to the flit, r_ready_out[2] high 2 edges after the request, dropped 1 edge after wr_ready_in[2] falls, flits_cnt=1.
- All 5 ports request continuously from reset -> grant order 0,1,2,3,4,0; every flit written once; at most one bit of r_ready_out high at any time.
- mem_full=1 for 10 cycles during WRITE on port 4 -> no mem_wr and r_ready_out=0 during the stall; write and ack on the first cycle after mem_full=0.
- Port 1 driven Z and port 3 X, port 0 real -> only port 0 is granted; r_ready_out[1] and [3] stay 0.
- CNT_SIZE=4, 17 flits -> flits_cnt reads 1 after wrap.
